// File: rtl/pb_mode_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pb_mode_pkg                                                                |
// | Shared FSM encodings and timing defaults for the push-button mode control. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pb_mode_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT2 = 2'd1,
        ST_REQ   = 2'd2
    } pb_state_e;

    localparam int unsigned c_DBL_WIN_DEF = 32'd2500000;
    localparam int unsigned c_ACK_TO_DEF  = 32'd1024;

    // Single press advances the mode, wrapping back to 0 after the last one.
    function automatic int unsigned wrap_inc(input int unsigned mode,
                                             input int unsigned num_modes);
        return (mode == num_modes - 1) ? 0 : mode + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pb_window_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pb_window_timer                                                            |
// | Clear/enable cycle counter; o_expired is high while count == LIMIT-1.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pb_window_timer #(
    parameter int unsigned LIMIT = 8
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned CNT_W = $clog2(LIMIT);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q <= '0;
        end else if (i_clr) begin
            cnt_q <= '0;
        end else if (i_en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign o_expired = (cnt_q == CNT_W'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/pb_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pb_mode_ctrl                                                               |
// | Classifies debounced presses as SINGLE/DOUBLE and hands the new mode to    |
// | the config logic over req/ack. PB_MODE_ACK_TO_EN adds an ack timeout.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pb_mode_ctrl
    import pb_mode_pkg::*;
#(
    parameter  int unsigned NUM_MODES = 4,
    parameter  int unsigned DBL_WIN   = c_DBL_WIN_DEF,
    parameter  int unsigned ACK_TO    = c_ACK_TO_DEF,
    localparam int unsigned MODE_W    = $clog2(NUM_MODES)
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_pb_pulse,
    input  logic              i_ack,
    output logic              o_req,
    output logic [MODE_W-1:0] o_req_mode,
    output logic [MODE_W-1:0] o_mode,
    output logic              o_dbl,
    output logic              o_busy,
    output logic              o_err
);

    pb_state_e         state_q;
    logic              req_q;
    logic [MODE_W-1:0] req_mode_q;
    logic [MODE_W-1:0] mode_q;
    logic              dbl_q;
    logic              busy_q;

    logic              w_win_expired;
    logic              w_ack_expired;
    logic [MODE_W-1:0] w_next_mode;

    assign w_next_mode = MODE_W'(wrap_inc(32'(mode_q), NUM_MODES));

    // Held clear outside WAIT2 so every window starts from zero.
    pb_window_timer #(
        .LIMIT     (DBL_WIN)
    ) u_win_timer (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_clr     (state_q != ST_WAIT2),
        .i_en      (state_q == ST_WAIT2),
        .o_expired (w_win_expired)
    );

`ifdef PB_MODE_ACK_TO_EN
    logic err_q;

    pb_window_timer #(
        .LIMIT     (ACK_TO)
    ) u_ack_timer (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_clr     (state_q != ST_REQ),
        .i_en      (state_q == ST_REQ),
        .o_expired (w_ack_expired)
    );

    assign o_err = err_q;
`else
    assign w_ack_expired = 1'b0;
    assign o_err         = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            req_mode_q <= '0;
            mode_q     <= '0;
            dbl_q      <= 1'b0;
            busy_q     <= 1'b0;
`ifdef PB_MODE_ACK_TO_EN
            err_q      <= 1'b0;
`endif
        end else begin
            dbl_q <= 1'b0;
`ifdef PB_MODE_ACK_TO_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (i_pb_pulse) begin
                        state_q <= ST_WAIT2;
                        busy_q  <= 1'b1;
                    end
                end
                ST_WAIT2: begin
                    // A second press on the expiry cycle still counts as DOUBLE.
                    if (i_pb_pulse) begin
                        req_mode_q <= '0;
                        dbl_q      <= 1'b1;
                        req_q      <= 1'b1;
                        state_q    <= ST_REQ;
                    end else if (w_win_expired) begin
                        req_mode_q <= w_next_mode;
                        req_q      <= 1'b1;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_ack) begin
                        mode_q  <= req_mode_q;
                        req_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (w_ack_expired) begin
                        req_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
`ifdef PB_MODE_ACK_TO_EN
                        err_q   <= 1'b1;
`endif
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req      = req_q;
    assign o_req_mode = req_mode_q;
    assign o_mode     = mode_q;
    assign o_dbl      = dbl_q;
    assign o_busy     = busy_q;

endmodule
`default_nettype wire
